univ_register: RTL and testbench

UNIV_REGISTER -- requirements
Module: univ_register

---
 rtl/univ_register.sv | 93 +++++++++
 tb/tb_univ_register.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/univ_register.sv
// Universal register: parallel load, left/right shift, modulo-M counter and
// a divide-by-2(M+1) output driven from the counter's terminal count.
module univ_register #(
    parameter int                 WIDTH      = 8,
    parameter logic [WIDTH-1:0]   PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             pre,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             tc,
    output logic             div_out
);

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'b00,
        MODE_SHL   = 2'b01,
        MODE_SHR   = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             div_q;
    logic             div_d;
    logic             at_term_s;
    logic             tc_s;
    logic             sout_s;
    mode_e            mode_s;

    assign mode_s    = mode_e'(mode);
    // ">=" rather than "==" so a value already past the modulus wraps at once
    assign at_term_s = (q_q >= modulus);
    assign tc_s      = en & ~rst & ~pre & (mode_s == MODE_COUNT) & at_term_s;

    // Serial output tap, selected purely by mode
    always_comb begin
        sout_s = 1'b0;
        case (mode_s)
            MODE_SHL: sout_s = q_q[WIDTH-1];
            MODE_SHR: sout_s = q_q[0];
            default:  sout_s = 1'b0;
        endcase
    end

    // Next-state selection: preset, then enabled operation, else hold
    always_comb begin
        q_d   = q_q;
        div_d = div_q;
        if (pre) begin
            q_d   = PRESET_VAL;
            div_d = 1'b1;
        end else if (en) begin
            case (mode_s)
                MODE_LOAD:  q_d = d;
                MODE_SHL:   q_d = {q_q[WIDTH-2:0], sin};
                MODE_SHR:   q_d = {sin, q_q[WIDTH-1:1]};
                MODE_COUNT: q_d = at_term_s ? ZERO_C : (q_q + ONE_C);
                default:    q_d = q_q;
            endcase
            div_d = div_q ^ tc_s;
        end else begin
            q_d   = q_q;
            div_d = div_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (rst) begin
            q_q   <= ZERO_C;
            div_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            div_q <= div_d;
        end
    end

    assign q       = q_q;
    assign div_out = div_q;
    assign tc      = tc_s;
    assign sout    = sout_s;

endmodule

// File: tb/tb_univ_register.sv
// Table-driven directed vectors plus randomized traffic against a plain
// arithmetic reference model of univ_register (WIDTH=8).
module tb_univ_register;

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] SHL = 2'b01;
    localparam logic [1:0] SHR = 2'b10;
    localparam logic [1:0] CNT = 2'b11;

    logic       clock = 1'b0;
    logic       rst = 1'b0, pre = 1'b0, en = 1'b0, sin = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00, modulus = 8'h00;
    logic [7:0] q;
    logic       sout, tc, div_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       r, p, e;
        logic [1:0] m;
        logic [7:0] dd;
        logic       s;
        logic [7:0] md;
        logic       exp_tc, exp_sout;
        logic [7:0] exp_q;
        logic       exp_div;
    } vec_t;

    vec_t tbl[$];

    univ_register #(.WIDTH(8), .PRESET_VAL(8'hFF)) dut (
        .clock(clock), .rst(rst), .pre(pre), .en(en), .mode(mode), .d(d),
        .sin(sin), .modulus(modulus), .q(q), .sout(sout), .tc(tc),
        .div_out(div_out)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic r, input logic p, input logic e,
                                input logic [1:0] m, input logic [7:0] dd,
                                input logic s, input logic [7:0] md,
                                input logic etc, input logic es,
                                input logic [7:0] eq, input logic ed);
        vec_t v;
        v.r = r; v.p = p; v.e = e; v.m = m; v.dd = dd; v.s = s; v.md = md;
        v.exp_tc = etc; v.exp_sout = es; v.exp_q = eq; v.exp_div = ed;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, check combinational outputs,
    // take one edge, then check registered outputs.
    task automatic run_vec(input vec_t v, input string tag);
        rst = v.r; pre = v.p; en = v.e; mode = v.m; d = v.dd; sin = v.s; modulus = v.md;
        #1;
        check({tag, ".tc"},   {31'd0, tc},   {31'd0, v.exp_tc});
        check({tag, ".sout"}, {31'd0, sout}, {31'd0, v.exp_sout});
        @(posedge clock);
        #1;
        check({tag, ".q"},    {24'd0, q},       {24'd0, v.exp_q});
        check({tag, ".div"},  {31'd0, div_out}, {31'd0, v.exp_div});
    endtask

    int mdl_q;
    int mdl_div;

    initial begin
        // Directed table: reset/preset priority, load+shift, count corners
        tbl.push_back(mk(1,1,1,CNT,8'h00,1'b0,8'h04, 1'b0,1'b0,8'h00,1'b0));
        tbl.push_back(mk(0,1,0,LD ,8'h00,1'b0,8'h00, 1'b0,1'b0,8'hFF,1'b1));
        tbl.push_back(mk(0,0,1,LD ,8'hA5,1'b0,8'h00, 1'b0,1'b0,8'hA5,1'b1));
        tbl.push_back(mk(0,0,1,SHL,8'h00,1'b1,8'h00, 1'b0,1'b1,8'h4B,1'b1));
        tbl.push_back(mk(0,0,1,SHL,8'h00,1'b1,8'h00, 1'b0,1'b0,8'h97,1'b1));
        tbl.push_back(mk(0,0,1,SHL,8'h00,1'b1,8'h00, 1'b0,1'b1,8'h2F,1'b1));
        tbl.push_back(mk(0,0,1,LD ,8'h10,1'b0,8'h03, 1'b0,1'b0,8'h10,1'b1));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'h03, 1'b1,1'b0,8'h00,1'b0));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'h03, 1'b0,1'b0,8'h01,1'b0));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'h03, 1'b0,1'b0,8'h02,1'b0));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'h03, 1'b0,1'b0,8'h03,1'b0));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'h03, 1'b1,1'b0,8'h00,1'b1));
        tbl.push_back(mk(1,0,1,CNT,8'h00,1'b0,8'h00, 1'b0,1'b0,8'h00,1'b0));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'h00, 1'b1,1'b0,8'h00,1'b1));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'h00, 1'b1,1'b0,8'h00,1'b0));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'h00, 1'b1,1'b0,8'h00,1'b1));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'h00, 1'b1,1'b0,8'h00,1'b0));
        tbl.push_back(mk(0,0,0,CNT,8'h00,1'b0,8'h00, 1'b0,1'b0,8'h00,1'b0));
        tbl.push_back(mk(0,0,0,CNT,8'h00,1'b0,8'h00, 1'b0,1'b0,8'h00,1'b0));
        tbl.push_back(mk(0,0,1,LD ,8'h81,1'b0,8'h00, 1'b0,1'b0,8'h81,1'b0));
        tbl.push_back(mk(0,0,1,SHR,8'h00,1'b0,8'h00, 1'b0,1'b1,8'h40,1'b0));
        tbl.push_back(mk(0,0,1,SHR,8'h00,1'b1,8'h00, 1'b0,1'b0,8'hA0,1'b0));
        tbl.push_back(mk(0,0,0,SHR,8'h00,1'b1,8'h00, 1'b0,1'b0,8'hA0,1'b0));
        tbl.push_back(mk(0,0,1,LD ,8'hFE,1'b0,8'hFF, 1'b0,1'b0,8'hFE,1'b0));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'hFF, 1'b0,1'b0,8'hFF,1'b0));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'hFF, 1'b1,1'b0,8'h00,1'b1));
        tbl.push_back(mk(0,1,1,SHL,8'h00,1'b0,8'h00, 1'b0,1'b0,8'hFF,1'b1));
        tbl.push_back(mk(0,0,1,CNT,8'h00,1'b0,8'h05, 1'b1,1'b0,8'h00,1'b0));
        tbl.push_back(mk(0,1,1,CNT,8'h00,1'b0,8'h00, 1'b0,1'b0,8'hFF,1'b1));

        #1;
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Modulus 4 run: period 5 on q, period 10 on div_out
        run_vec(mk(1,0,0,LD,8'h00,1'b0,8'h00, 1'b0,1'b0,8'h00,1'b0), "m4.rst");
        for (int k = 0; k < 20; k++)
            run_vec(mk(0,0,1,CNT,8'h00,1'b0,8'h04, 1'((k % 5) == 4), 1'b0,
                       8'((k + 1) % 5), 1'(((k + 1) / 5) % 2)), $sformatf("m4.%0d", k));

        // Modulus 9: reset mid-count abandons it, count restarts from 0
        run_vec(mk(1,0,0,LD,8'h00,1'b0,8'h00, 1'b0,1'b0,8'h00,1'b0), "m9.rst0");
        for (int k = 0; k < 6; k++)
            run_vec(mk(0,0,1,CNT,8'h00,1'b0,8'h09, 1'b0,1'b0,8'(k + 1),1'b0), $sformatf("m9a.%0d", k));
        run_vec(mk(1,0,1,CNT,8'h00,1'b0,8'h09, 1'b0,1'b0,8'h00,1'b0), "m9.rst1");
        for (int k = 0; k < 10; k++)
            run_vec(mk(0,0,1,CNT,8'h00,1'b0,8'h09, 1'(k == 9), 1'b0,
                       (k == 9) ? 8'h00 : 8'(k + 1), 1'(k == 9)), $sformatf("m9b.%0d", k));

        // Randomized traffic against the arithmetic model
        run_vec(mk(1,0,0,LD,8'h00,1'b0,8'h00, 1'b0,1'b0,8'h00,1'b0), "rnd.rst");
        mdl_q = 0;
        mdl_div = 0;
        for (int i = 0; i < 600; i++) begin
            vec_t v;
            int nq;
            int tcv;
            v.r  = ($urandom_range(0, 31) == 0);
            v.p  = ($urandom_range(0, 31) == 0);
            v.e  = ($urandom_range(0, 3) != 0);
            v.m  = 2'($urandom_range(0, 3));
            v.dd = 8'($urandom_range(0, 255));
            v.s  = 1'($urandom_range(0, 1));
            v.md = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 12));
            tcv = (!v.r && !v.p && v.e && v.m == CNT && mdl_q >= int'(v.md)) ? 1 : 0;
            v.exp_tc   = 1'(tcv);
            v.exp_sout = (v.m == SHL) ? 1'(mdl_q / 128) :
                         (v.m == SHR) ? 1'(mdl_q % 2) : 1'b0;
            nq = mdl_q;
            if (v.r) begin
                nq = 0; mdl_div = 0;
            end else if (v.p) begin
                nq = 255; mdl_div = 1;
            end else if (v.e) begin
                if (v.m == LD)       nq = int'(v.dd);
                else if (v.m == SHL) nq = (mdl_q * 2 + int'(v.s)) % 256;
                else if (v.m == SHR) nq = mdl_q / 2 + int'(v.s) * 128;
                else                 nq = (mdl_q >= int'(v.md)) ? 0 : mdl_q + 1;
                mdl_div = (mdl_div + tcv) % 2;
            end
            mdl_q = nq;
            v.exp_q   = 8'(mdl_q);
            v.exp_div = 1'(mdl_div);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
